// File: rtl/pwm_driver_if.sv
// pwm_driver_if -- control/status bundle for pwm_driver.
//
// Handshake: pwm_update is a level request sampled on every rising clock
// edge. It is only accepted while pwm_enable=1; each accepted clock
// overwrites the shadow ratio/direction. pwm_done is a one-cycle pulse
// that reports when a shadow value has become the applied value.
//
// Signals:
//   pwm_enable     master->slave  1 = run, 0 = stop (level)
//   pwm_update     master->slave  load request for ratio/direction (level)
//   pwm_ratio      master->slave  requested high-time out of 255
//   pwm_direction  master->slave  requested motor direction
//   pwm_done       slave->master  one-cycle pulse, request took effect
//   pwm_out        slave->master  PWM signal to the motor bridge
//   dir_out        slave->master  applied direction
//   debug_signals  slave->master  {4'b0, period_cnt, pending, dir_out, state}
interface pwm_driver_if;
  logic        pwm_enable;
  logic        pwm_update;
  logic [7:0]  pwm_ratio;
  logic        pwm_direction;
  logic        pwm_done;
  logic        pwm_out;
  logic        dir_out;
  logic [15:0] debug_signals;

  modport master (
    output pwm_enable, pwm_update, pwm_ratio, pwm_direction,
    input  pwm_done, pwm_out, dir_out, debug_signals
  );

  modport slave (
    input  pwm_enable, pwm_update, pwm_ratio, pwm_direction,
    output pwm_done, pwm_out, dir_out, debug_signals
  );
endinterface

// File: rtl/pwm_driver.sv
// pwm_driver -- 255-step PWM generator for a motor bridge with
// shadowed ratio/direction updates applied on period boundaries.
//
// Optional feature: define PWM_DIRECTION_DEADTIME_EN to hold the output
// low for DEADTIME_PERIODS full periods whenever the direction reverses.
// Without the macro a reversal is applied at the boundary like any
// other update.
//
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      pwm_driver_if.slave (enable/update/ratio/direction in,
//            done/pwm_out/dir_out/debug_signals out)
//
// Parameters:
//   CLK_DIV           clock cycles per PWM tick (1..65535)
//   DEADTIME_PERIODS  forced-low periods on reversal (1..255)
module pwm_driver #(
  parameter int CLK_DIV          = 4,
  parameter int DEADTIME_PERIODS = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  pwm_driver_if.slave bus
);

  localparam logic [1:0]  ST_IDLE = 2'b00;
  localparam logic [1:0]  ST_RUN  = 2'b01;
  localparam logic [1:0]  ST_DEAD = 2'b10;
  localparam logic [15:0] DIV_MAX = 16'(CLK_DIV - 1);
  localparam logic [7:0]  DT_MAX  = 8'(DEADTIME_PERIODS - 1);
  localparam logic [7:0]  CNT_MAX = 8'd254;

  logic [1:0]  state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  ratio_q, ratio_d;
  logic        dir_q, dir_d;
  logic [7:0]  sh_ratio_q, sh_ratio_d;
  logic        sh_dir_q, sh_dir_d;
  logic        pending_q, pending_d;
  logic        out_q, out_d;
  logic        done_q, done_d;
  logic [7:0]  dt_q, dt_d;

  logic en;
  logic tick;
  logic boundary;
  logic dir_change;
  logic idle_start;
  logic run_apply;
  logic dt_exit;
  logic counting;

  assign en       = bus.pwm_enable;
  assign tick     = (div_q == DIV_MAX);
  assign boundary = tick && (cnt_q == CNT_MAX);

`ifdef PWM_DIRECTION_DEADTIME_EN
  // A pending reversal diverts the boundary into DEADTIME instead of
  // applying the shadow directly.
  assign dir_change = (sh_dir_q != dir_q);
  assign dt_exit    = en && (state_q == ST_DEAD) && boundary && (dt_q == DT_MAX);
`else
  assign dir_change = 1'b0;
  assign dt_exit    = 1'b0;
`endif

  assign idle_start = en && (state_q == ST_IDLE) && pending_q;
  assign run_apply  = en && (state_q == ST_RUN) && boundary && pending_q && !dir_change;
  assign counting   = en && ((state_q == ST_RUN) || (state_q == ST_DEAD));

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (pending_q) state_d = ST_RUN;
        ST_RUN:  if (boundary && pending_q && dir_change) state_d = ST_DEAD;
`ifdef PWM_DIRECTION_DEADTIME_EN
        ST_DEAD: if (boundary && (dt_q == DT_MAX)) state_d = ST_RUN;
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    div_d      = div_q;
    cnt_d      = cnt_q;
    ratio_d    = ratio_q;
    dir_d      = dir_q;
    sh_ratio_d = sh_ratio_q;
    sh_dir_d   = sh_dir_q;
    pending_d  = pending_q;
    dt_d       = dt_q;
    done_d     = 1'b0;
    // Compare against the current count; the register delays pwm_out by
    // one clock so ratio 255 stays high through the wrap at 254.
    out_d      = en && (state_q == ST_RUN) && (cnt_q < ratio_q);

    if (counting) begin
      if (tick) begin
        div_d = '0;
        cnt_d = (cnt_q == CNT_MAX) ? 8'd0 : cnt_q + 8'd1;
      end else begin
        div_d = div_q + 16'd1;
      end
    end else begin
      div_d = '0;
      cnt_d = '0;
    end

    if (en && (state_q == ST_DEAD) && boundary) begin
      dt_d = (dt_q == DT_MAX) ? 8'd0 : dt_q + 8'd1;
    end else if (state_q != ST_DEAD) begin
      dt_d = '0;
    end

    // The shadow used here is the registered one, so an update arriving
    // on this same clock is held for the next boundary.
    if (idle_start || run_apply || dt_exit) begin
      ratio_d   = sh_ratio_q;
      dir_d     = sh_dir_q;
      pending_d = 1'b0;
      done_d    = 1'b1;
    end

    if (en && bus.pwm_update) begin
      sh_ratio_d = bus.pwm_ratio;
      sh_dir_d   = bus.pwm_direction;
      pending_d  = 1'b1;
    end

    if (!en) begin
      pending_d = 1'b0;
      ratio_d   = '0;
      dt_d      = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_q      <= '0;
      cnt_q      <= '0;
      ratio_q    <= '0;
      dir_q      <= 1'b0;
      sh_ratio_q <= '0;
      sh_dir_q   <= 1'b0;
      pending_q  <= 1'b0;
      out_q      <= 1'b0;
      done_q     <= 1'b0;
      dt_q       <= '0;
    end else begin
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      ratio_q    <= ratio_d;
      dir_q      <= dir_d;
      sh_ratio_q <= sh_ratio_d;
      sh_dir_q   <= sh_dir_d;
      pending_q  <= pending_d;
      out_q      <= out_d;
      done_q     <= done_d;
      dt_q       <= dt_d;
    end
  end

  assign bus.pwm_out       = out_q;
  assign bus.pwm_done      = done_q;
  assign bus.dir_out       = dir_q;
  assign bus.debug_signals = {4'b0000, cnt_q, pending_q, dir_q, state_q};

endmodule

// File: tb/tb_pwm_driver.sv
// tb_pwm_driver -- directed bench for pwm_driver with CLK_DIV=1,
// DEADTIME_PERIODS=2. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_pwm_driver;

`ifdef PWM_DIRECTION_DEADTIME_EN
  localparam int EXP_DT = 510;
`else
  localparam int EXP_DT = 0;
`endif

  logic clock;
  logic reset_n;
  pwm_driver_if bus();

  pwm_driver #(.CLK_DIV(1), .DEADTIME_PERIODS(2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [7:0] ratio;
    logic       dir;
    int         exp_high;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One falling edge; every wait goes through here so pwm_done pulses
  // are counted exactly once.
  task automatic step();
    @(negedge clock);
    if (bus.pwm_done) done_cnt++;
  endtask

  task automatic send_update(input logic [7:0] r, input logic d, input int max,
                             output int lat, output bit got);
    bus.pwm_ratio     = r;
    bus.pwm_direction = d;
    bus.pwm_update    = 1'b1;
    lat = 0;
    got = 1'b0;
    while (!got && lat < max) begin
      step();
      lat++;
      if (lat == 1) bus.pwm_update = 1'b0;
      if (bus.pwm_done) got = 1'b1;
    end
    bus.pwm_update = 1'b0;
  endtask

  task automatic measure(input int n, output int highs, output int dones);
    highs = 0;
    dones = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (bus.pwm_out) highs++;
      if (bus.pwm_done) dones++;
    end
  endtask

  task automatic wait_cnt(input int value);
    bit found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      step();
      if (int'(bus.debug_signals[11:4]) == value) found = 1'b1;
    end
    check("wait_period_cnt", int'(found), 1);
  endtask

  initial begin
    int lat, h, d, n, dtc, dth, dtd, base;
    bit got;

    vecs[0] = '{ratio: 8'd64,  dir: 1'b0, exp_high: 64};
    vecs[1] = '{ratio: 8'd192, dir: 1'b0, exp_high: 192};
    vecs[2] = '{ratio: 8'd1,   dir: 1'b0, exp_high: 1};
    vecs[3] = '{ratio: 8'd254, dir: 1'b0, exp_high: 254};
    vecs[4] = '{ratio: 8'd0,   dir: 1'b0, exp_high: 0};
    vecs[5] = '{ratio: 8'd255, dir: 1'b0, exp_high: 255};

    reset_n           = 1'b0;
    bus.pwm_enable    = 1'b0;
    bus.pwm_update    = 1'b0;
    bus.pwm_ratio     = 8'd0;
    bus.pwm_direction = 1'b0;
    repeat (3) step();
    check("rst_pwm_out", int'(bus.pwm_out), 0);
    check("rst_dir_out", int'(bus.dir_out), 0);
    check("rst_done", int'(bus.pwm_done), 0);
    check("rst_debug", int'(bus.debug_signals), 0);
    reset_n = 1'b1;
    repeat (2) step();
    check("idle_after_rst", int'(bus.debug_signals[1:0]), 0);

    // First start from IDLE: done arrives with the first RUN clock.
    bus.pwm_enable = 1'b1;
    send_update(8'd128, 1'b0, 600, lat, got);
    check("start_done", int'(got), 1);
    check("start_latency", lat, 2);
    check("start_state_run", int'(bus.debug_signals[1:0]), 1);
    measure(255, h, d);
    check("start_high128", h, 128);
    check("start_single_done", d, 0);

    // Ratio table: each update applied at the next boundary.
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(32'(vecs[i].exp_high));
      send_update(vecs[i].ratio, vecs[i].dir, 600, lat, got);
      check("vec_done", int'(got), 1);
      measure(255, h, d);
      check("vec_high", h, int'(exp_q.pop_front()));
      check("vec_no_extra_done", d, 0);
      check("vec_dir", int'(bus.dir_out), int'(vecs[i].dir));
    end
    // Ratio 255 stays high across further boundaries.
    measure(300, h, d);
    check("full_no_glitch", h, 300);

    // Mid-period 64 -> 192: current period still finishes at 64.
    send_update(8'd64, 1'b0, 600, lat, got);
    check("set64_done", int'(got), 1);
    wait_cnt(30);
    bus.pwm_ratio  = 8'd192;
    bus.pwm_update = 1'b1;
    h = 0;
    got = 1'b0;
    n = 0;
    while (!got && n < 600) begin
      step();
      n++;
      if (n == 1) bus.pwm_update = 1'b0;
      if (bus.pwm_out) h++;
      if (bus.pwm_done) got = 1'b1;
    end
    check("mid_done", int'(got), 1);
    check("mid_old_tail_high", h, 34);
    measure(255, h, d);
    check("mid_new_high", h, 192);
    check("mid_one_done", d, 0);

    // Update on the boundary clock applies one period later.
    wait_cnt(254);
    send_update(8'd50, 1'b0, 600, lat, got);
    check("bnd_done", int'(got), 1);
    check("bnd_latency", lat, 256);
    measure(255, h, d);
    check("bnd_high", h, 50);

    // Direction reversal at ratio 100.
    send_update(8'd100, 1'b0, 600, lat, got);
    check("dir_pre_done", int'(got), 1);
    wait_cnt(10);
    bus.pwm_ratio     = 8'd100;
    bus.pwm_direction = 1'b1;
    bus.pwm_update    = 1'b1;
    dtc = 0; dth = 0; dtd = 0; n = 0;
    got = 1'b0;
    while (!got && n < 1500) begin
      step();
      n++;
      if (n == 1) bus.pwm_update = 1'b0;
      if (bus.debug_signals[1:0] == 2'b10) begin
        dtc++;
        if (bus.pwm_out) dth++;
        if (bus.dir_out) dtd++;
      end
      if (bus.pwm_done) got = 1'b1;
    end
    check("dir_done", int'(got), 1);
    check("dir_dead_cycles", dtc, EXP_DT);
    check("dir_dead_out_low", dth, 0);
    check("dir_dead_dir_held", dtd, 0);
    check("dir_applied", int'(bus.dir_out), 1);
    check("dir_state_run", int'(bus.debug_signals[1:0]), 1);
    measure(255, h, d);
    check("dir_high", h, 100);
    check("dir_one_done", d, 0);

    // Enable dropped mid-high.
    wait_cnt(20);
    check("en_pre_high", int'(bus.pwm_out), 1);
    base = done_cnt;
    bus.pwm_enable = 1'b0;
    step();
    check("en_out_low", int'(bus.pwm_out), 0);
    check("en_state_idle", int'(bus.debug_signals[1:0]), 0);
    check("en_cnt_zero", int'(bus.debug_signals[11:4]), 0);
    check("en_dir_hold", int'(bus.dir_out), 1);
    bus.pwm_ratio  = 8'd77;
    bus.pwm_update = 1'b1;
    step();
    bus.pwm_update = 1'b0;
    repeat (3) step();
    check("dis_no_pending", int'(bus.debug_signals[3]), 0);
    check("dis_no_done", done_cnt - base, 0);
    bus.pwm_enable = 1'b1;
    repeat (4) step();
    check("reen_stays_idle", int'(bus.debug_signals[1:0]), 0);
    send_update(8'd100, 1'b1, 600, lat, got);
    check("restart_done", int'(got), 1);
    check("restart_latency", lat, 2);

    // Reset pulsed mid-high: output drops without a clock edge.
    wait_cnt(20);
    check("rstp_pre_high", int'(bus.pwm_out), 1);
    base = done_cnt;
    #2 reset_n = 1'b0;
    #1;
    check("rstp_out_async", int'(bus.pwm_out), 0);
    check("rstp_state", int'(bus.debug_signals[1:0]), 0);
    check("rstp_dir", int'(bus.dir_out), 0);
    check("rstp_debug", int'(bus.debug_signals), 0);
    step();
    reset_n = 1'b1;
    repeat (3) step();
    check("rstp_idle_after", int'(bus.debug_signals[1:0]), 0);
    check("rstp_out_after", int'(bus.pwm_out), 0);
    check("rstp_no_done", done_cnt - base, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_driver.md
PWM_DRIVER -- requirements
Module: pwm_driver

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clock cycles per PWM tick, legal range 1..65535.
REQ-002 SHALL have parameter DEADTIME_PERIODS, default 2: full PWM periods of forced-low output on a direction reversal, legal range 1..255.
REQ-003 SHALL have port clock, input, 1 bit: the main clock; all logic is on the rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port pwm_enable, input, 1 bit: level; 1 = run, 0 = stop.
REQ-006 SHALL have port pwm_update, input, 1 bit: level; request to load pwm_ratio and pwm_direction.
REQ-007 SHALL have port pwm_ratio, input, 8 bits: requested high-time out of 255.
REQ-008 SHALL have port pwm_direction, input, 1 bit: requested motor direction.
REQ-009 SHALL have port pwm_done, output, 1 bit: one-cycle pulse when a requested ratio/direction takes effect.
REQ-010 SHALL have port pwm_out, output, 1 bit: the PWM signal to the motor bridge.
REQ-011 SHALL have port dir_out, output, 1 bit: the applied direction.
REQ-012 SHALL have port debug_signals, output, 16 bits: {4'b0, period_cnt[7:0], pending, dir_out, state[1:0]}.

Function
REQ-013 SHALL use states IDLE=2'b00, RUN=2'b01, DEADTIME=2'b10; the encoding 2'b11 SHALL recover to IDLE on the next clock.
REQ-014 SHALL generate a tick on the clock where the divider counter equals CLK_DIV-1, and then reset the divider to 0.
REQ-015 SHALL advance an 8-bit period counter by one on each tick, counting 0..254 and wrapping to 0; the tick at count 254 is the period boundary.
REQ-016 SHALL drive pwm_out (registered) as 1 in RUN when period_cnt < active_ratio, and as 0 otherwise; ratio 0 gives constant low and ratio 255 gives constant high.
REQ-017 SHALL load the shadow ratio and shadow direction and set pending on every clock where pwm_update=1 and pwm_enable=1; the last value before a boundary wins.
REQ-018 SHALL apply, at a boundary, only shadow values registered before that boundary clock; an update on the boundary clock itself takes effect at the next boundary.
REQ-019 SHALL do the following at a RUN boundary with pending=1 and shadow direction equal to dir_out: active_ratio <= shadow ratio, pending cleared, pwm_done pulsed on the following clock.
REQ-020 SHALL treat a boundary with pending=0 as leaving active_ratio unchanged, with no pwm_done.
REQ-021 SHALL move IDLE->RUN when pwm_enable=1 and pending=1, with counters zeroed, dir_out and active_ratio loaded from shadow, and pwm_done pulsed on the following clock; there is no dead time from IDLE.
REQ-022 SHALL, on pwm_enable=0 in any state, go to IDLE on the next clock with pwm_out=0, counters zeroed, pending cleared and active_ratio=0; dir_out holds its value.
REQ-023 SHALL NOT pulse pwm_done while pwm_enable=0.

Reset
REQ-024 SHALL, while reset_n=0, force state=IDLE, pwm_out=0, dir_out=0, pwm_done=0, period_cnt=0, divider=0, active_ratio=0, shadow=0, pending=0, and the DEADTIME counter=0.
REQ-025 SHALL resume from IDLE on the first clock after reset_n rises; reset applied mid-period SHALL drop pwm_out within the reset assertion, without waiting for a clock.

Configuration
REQ-026 SHALL provide macro PWM_DIRECTION_DEADTIME_EN.
REQ-027 SHALL, when PWM_DIRECTION_DEADTIME_EN is defined, handle a RUN boundary where shadow direction differs from dir_out by entering DEADTIME: pwm_out=0 for DEADTIME_PERIODS full periods, then dir_out and active_ratio updated, return to RUN, and pwm_done pulsed; updates during DEADTIME only refresh the shadow and pending.
REQ-028 SHALL, when PWM_DIRECTION_DEADTIME_EN is undefined, make the DEADTIME state unreachable and apply a direction change at the boundary exactly as in REQ-019, updating dir_out and active_ratio together.

Verification (CLK_DIV=1, DEADTIME_PERIODS=2)
REQ-029 SHALL check: enable=1, update with ratio=128 -> pwm_done one clock after entering RUN; pwm_out high 128 of every 255 clocks.
REQ-030 SHALL check: ratio=0, then ratio=255 -> pwm_out never high, then constant high across the period boundary with no glitch.
REQ-031 SHALL check: ratio 64->192 updated mid-period -> the current period completes at 64, the next period is at 192, and exactly one pwm_done.
REQ-032 SHALL check: update asserted on the boundary clock -> the value applies one period later.
REQ-033 SHALL check, with the macro on: direction 0->1 at ratio 100 -> pwm_out=0 for 510 clocks, then dir_out=1, then ratio 100 and pwm_done; with the macro off -> immediate switch at the boundary.
REQ-034 SHALL check: pwm_enable dropped mid-high, and separately reset_n pulsed mid-high -> pwm_out=0 next clock (enable) or immediately (reset), state=IDLE, and no pwm_done.
